// File: rtl/sme_pkg.sv
// Shared SME opcode encoding plus the latency and legality helpers used by the
// ALU scheduler and its arbiter.
package sme_pkg;

  typedef enum logic [3:0] {
    SME_AND    = 4'd0,
    SME_OR     = 4'd1,
    SME_XOR    = 4'd2,
    SME_ANDN   = 4'd3,
    SME_ORN    = 4'd4,
    SME_XNOR   = 4'd5,
    SME_NOT    = 4'd6,
    SME_SLL    = 4'd7,
    SME_SRL    = 4'd8,
    SME_ROL    = 4'd9,
    SME_ROR    = 4'd10,
    SME_UNMASK = 4'd11
  } sme_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } sched_state_t;

  // Everything above the last defined opcode is reserved.
  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op > 4'(SME_UNMASK));
  endfunction

  // The DOM AND and the unmask gate register internally, so their results
  // appear one cycle later than the purely combinational operations.
  function automatic logic [1:0] lat_of(input logic [3:0] op);
    case (op)
      4'(SME_AND), 4'(SME_OR), 4'(SME_ANDN), 4'(SME_ORN), 4'(SME_UNMASK):
        lat_of = 2'd2;
      default:
        lat_of = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/sme_sched_arb.sv
// Two-requester arbiter: the core issue port wins by default, while the remask
// engine is promoted once it has lost STARVE_MAX arbitrations in a row.
module sme_sched_arb
  import sme_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output logic       grant_id
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_reg;
  logic [SW-1:0] starve_next;
  logic          starved;

  assign starved  = (starve_reg == SW'(STARVE_MAX));
  assign grant_id = req_valid[1] && (starved || !req_valid[0]);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = en && req_valid[gi] && (grant_id == (gi == 1));
    end
  endgenerate

  // Losing to requester 0 can only happen when both bits are valid.
  always_comb begin
    starve_next = starve_reg;
    if (en && req_valid[1]) begin
      if (grant_id)
        starve_next = '0;
      else if (!starved)
        starve_next = starve_reg + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      starve_reg <= '0;
    else
      starve_reg <= starve_next;
  end

endmodule

// File: rtl/sme_alu_sched.sv
// Issue scheduler for the masked sme_alu: arbitrates two requesters, holds the
// operation steady for its latency and returns a response with owner and error.
module sme_alu_sched
  import sme_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic       g_clk,
  input  logic       g_reset,
  input  logic       flush,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req1_op,
  input  logic [4:0] req0_shamt,
  input  logic [4:0] req1_shamt,
  output logic       alu_valid,
  output logic [3:0] alu_op,
  output logic [4:0] alu_shamt,
  output logic       alu_sel,
  output logic       alu_flush,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic       rsp_err
);

  // Shift amounts wrap at the datapath width.
  localparam logic [4:0] SHAMT_MASK = 5'(XLEN - 1);

  sched_state_t state_reg, state_next;
  logic [1:0]   cnt_reg, cnt_next;
  logic [3:0]   op_reg, op_next;
  logic [4:0]   shamt_reg, shamt_next;
  logic         id_reg, id_next;

  logic         live;
  logic         exec;
  logic         arb_en;
  logic         grant_id;
  logic         handshake;
  logic [3:0]   op_sel;

  assign live      = !g_reset;
  assign exec      = live && (state_reg == ST_EXEC);
  assign arb_en    = live && (state_reg == ST_IDLE) && !flush;
  assign handshake = |req_ready;
  assign op_sel    = grant_id ? req1_op : req0_op;

  sme_sched_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (g_clk),
    .srst     (g_reset),
    .en       (arb_en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .grant_id (grant_id)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    shamt_next = shamt_reg;
    id_next    = id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (handshake) begin
          op_next    = op_sel;
          shamt_next = grant_id ? req1_shamt : req0_shamt;
          id_next    = grant_id;
          cnt_next   = lat_of(op_sel) - 2'd1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_reg != 2'd0)
          cnt_next = cnt_reg - 2'd1;
        else if (rsp_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // An aborted operation never reaches its response cycle.
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = 2'd0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 2'd0;
      op_reg    <= 4'd0;
      shamt_reg <= 5'd0;
      id_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      shamt_reg <= shamt_next;
      id_reg    <= id_next;
    end
  end

  assign alu_valid = exec && !is_illegal(op_reg);
  assign alu_op    = live ? op_reg : 4'd0;
  assign alu_shamt = live ? (shamt_reg & SHAMT_MASK) : 5'd0;
  assign alu_sel   = live && id_reg;
  assign alu_flush = live && flush;
  assign rsp_valid = exec && (cnt_reg == 2'd0) && !flush;
  assign rsp_id    = live && id_reg;
  assign rsp_err   = rsp_valid && is_illegal(op_reg);

endmodule

// File: tb/tb_sme_alu_sched.sv
// Self-checking bench for sme_alu_sched: vector table, hand-written corner
// sequences and a randomized phase against an arbitration/latency model.
module tb_sme_alu_sched;
  import sme_pkg::*;

  localparam int STARVE_MAX = 8;

  logic       g_clk = 1'b0;
  logic       g_reset;
  logic       flush;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_op, req1_op;
  logic [4:0] req0_shamt, req1_shamt;
  logic       alu_valid;
  logic [3:0] alu_op;
  logic [4:0] alu_shamt;
  logic       alu_sel;
  logic       alu_flush;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic       rsp_err;

  logic [16:0] all_out;
  assign all_out = {req_ready, alu_valid, alu_op, alu_shamt, alu_sel,
                    alu_flush, rsp_valid, rsp_id, rsp_err};

  sme_alu_sched #(.XLEN(32), .STARVE_MAX(STARVE_MAX)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .req0_shamt(req0_shamt),
    .req1_shamt(req1_shamt),
    .alu_valid (alu_valid),
    .alu_op    (alu_op),
    .alu_shamt (alu_shamt),
    .alu_sel   (alu_sel),
    .alu_flush (alu_flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;
  int starve_m = 0;

  typedef struct {
    logic [1:0] mask;
    logic [3:0] op;
    logic [4:0] sh;
    int         delay;
    int         lat;
    bit         err;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: latency and legality straight from the opcode list.
  function automatic int ref_lat(input logic [3:0] op);
    if (op == SME_AND || op == SME_OR || op == SME_ANDN || op == SME_ORN || op == SME_UNMASK)
      return 2;
    return 1;
  endfunction

  function automatic bit ref_err(input logic [3:0] op);
    return op > 4'd11;
  endfunction

  function automatic int ref_winner(input logic [1:0] mask);
    if (mask == 2'b11) return (starve_m == STARVE_MAX) ? 1 : 0;
    return (mask == 2'b10) ? 1 : 0;
  endfunction

  // One IDLE arbitration cycle ending in a handshake; returns model and observed winners.
  task automatic issue(input logic [1:0] mask, input logic [3:0] op0, input logic [3:0] op1,
                       input logic [4:0] sh0, input logic [4:0] sh1,
                       output int w, output int gid);
    @(negedge g_clk);
    req_valid = mask; req0_op = op0; req1_op = op1;
    req0_shamt = sh0; req1_shamt = sh1;
    flush = 1'b0; rsp_ready = 1'b0;
    #1;
    w = ref_winner(mask);
    chk("req_ready", 32'(req_ready), 32'(2'b01 << w));
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_alu_valid", 32'(alu_valid), 0);
    gid = (req_ready == 2'b10) ? 1 : 0;
    $display("issue mask=%b op0=%h op1=%h winner=%0d starve=%0d", mask, op0, op1, w, starve_m);
    if (w == 0 && mask[1]) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
    if (w == 1) starve_m = 0;
    @(posedge g_clk);
    #1;
    req_valid = 2'b00;
  endtask

  // EXEC phase: response appears after lat cycles, accepted after delay more.
  task automatic complete(input logic [3:0] op, input logic [4:0] sh, input int id,
                          input int lat, input bit err, input int delay);
    for (int c = 1; c <= lat + delay; c++) begin
      @(negedge g_clk);
      rsp_ready = (c >= lat + delay);
      #1;
      chk("alu_valid", 32'(alu_valid), 32'(!err));
      chk("alu_op", 32'(alu_op), 32'(op));
      chk("alu_shamt", 32'(alu_shamt), 32'(sh));
      chk("alu_sel", 32'(alu_sel), 32'(id));
      chk("rsp_valid", 32'(rsp_valid), 32'(c >= lat));
      if (c >= lat) begin
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_err", 32'(rsp_err), 32'(err));
      end
    end
    @(posedge g_clk);
    #1;
    rsp_ready = 1'b0;
    $display("done op=%h id=%0d lat=%0d err=%0d delay=%0d", op, id, lat, err, delay);
  endtask

  initial begin
    int w, gid;
    logic [1:0] m;
    logic [3:0] o0, o1, op;
    logic [4:0] s0, s1, sh;
    int dly;

    vt[0] = '{2'b01, SME_XOR,    5'd0,  0, 1, 1'b0};
    vt[1] = '{2'b10, SME_AND,    5'd0,  3, 2, 1'b0};
    vt[2] = '{2'b01, SME_OR,     5'd3,  0, 2, 1'b0};
    vt[3] = '{2'b10, SME_ANDN,   5'd1,  1, 2, 1'b0};
    vt[4] = '{2'b01, SME_ORN,    5'd2,  0, 2, 1'b0};
    vt[5] = '{2'b10, SME_UNMASK, 5'd0,  2, 2, 1'b0};
    vt[6] = '{2'b01, SME_SLL,    5'd7,  0, 1, 1'b0};
    vt[7] = '{2'b10, SME_ROR,    5'd31, 1, 1, 1'b0};
    vt[8] = '{2'b01, 4'hF,       5'd4,  0, 1, 1'b1};
    vt[9] = '{2'b10, 4'hC,       5'd9,  2, 1, 1'b1};

    // Reset with busy inputs: everything must read zero.
    g_reset = 1'b1; flush = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req0_op = SME_AND; req1_op = SME_OR; req0_shamt = 5'd5; req1_shamt = 5'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      #1;
      chk("reset_outputs", 32'(all_out), 0);
    end
    @(negedge g_clk);
    g_reset = 1'b0; flush = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    starve_m = 0;

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].mask, vt[i].op, vt[i].op, vt[i].sh, vt[i].sh, w, gid);
      complete(vt[i].op, vt[i].sh, int'(vt[i].mask[1]), vt[i].lat, vt[i].err, vt[i].delay);
    end

    // Continuous contention: requester 1 wins the 9th arbitration only.
    for (int i = 0; i < 10; i++) begin
      issue(2'b11, SME_XOR, SME_XNOR, 5'd1, 5'd2, w, gid);
      chk("starve_grant", 32'(gid), 32'(i == 8));
      complete((w == 1) ? SME_XNOR : SME_XOR, (w == 1) ? 5'd2 : 5'd1, w, 1, 1'b0, 0);
    end

    // Flush right after an AND handshake, with a request pending.
    issue(2'b01, SME_AND, SME_AND, 5'd0, 5'd0, w, gid);
    @(negedge g_clk);
    flush = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    chk("flush_alu_flush", 32'(alu_flush), 1);
    chk("flush_rsp_valid", 32'(rsp_valid), 0);
    chk("flush_req_ready", 32'(req_ready), 0);
    @(posedge g_clk);
    #1;
    flush = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    @(negedge g_clk);
    #1;
    chk("post_flush_rsp", 32'(rsp_valid), 0);
    chk("post_flush_alu_valid", 32'(alu_valid), 0);
    issue(2'b01, SME_XOR, SME_XOR, 5'd3, 5'd3, w, gid);
    complete(SME_XOR, 5'd3, 0, 1, 1'b0, 0);

    // Flush coinciding with rsp_ready on a ready response.
    issue(2'b10, SME_XOR, SME_XOR, 5'd0, 5'd0, w, gid);
    @(negedge g_clk);
    flush = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("flush_vs_ready_rsp", 32'(rsp_valid), 0);
    chk("flush_vs_ready_flush", 32'(alu_flush), 1);
    @(posedge g_clk);
    #1;
    flush = 1'b0; rsp_ready = 1'b0;

    // Flush in IDLE with both requests: no grant, starve count untouched.
    @(negedge g_clk);
    flush = 1'b1; req_valid = 2'b11;
    #1;
    chk("idle_flush_ready", 32'(req_ready), 0);
    chk("idle_flush_alu_flush", 32'(alu_flush), 1);
    @(posedge g_clk);
    #1;
    flush = 1'b0; req_valid = 2'b00;

    // Reset in the middle of an OR.
    issue(2'b01, SME_OR, SME_OR, 5'd4, 5'd4, w, gid);
    @(negedge g_clk);
    g_reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    @(negedge g_clk);
    #1;
    chk("reset_exec_outputs", 32'(all_out), 0);
    g_reset = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    starve_m = 0;
    @(negedge g_clk);
    #1;
    chk("post_reset_rsp", 32'(rsp_valid), 0);
    chk("post_reset_alu_valid", 32'(alu_valid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      m   = 2'($urandom_range(1, 3));
      o0  = 4'($urandom_range(0, 15));
      o1  = 4'($urandom_range(0, 15));
      s0  = 5'($urandom_range(0, 31));
      s1  = 5'($urandom_range(0, 31));
      dly = $urandom_range(0, 3);
      issue(m, o0, o1, s0, s1, w, gid);
      op = (w == 1) ? o1 : o0;
      sh = (w == 1) ? s1 : s0;
      complete(op, sh, w, ref_lat(op), ref_err(op), dly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
